// File: rtl/ebus_ctl_if.sv
// EBUS controller signal bundle: APR/PI requests, device handshake and bus outputs.
// The slave modport is the controller's view; master is the requester/device side.
interface ebus_ctl_if #(
   parameter int DW = 36
);
   logic          apr_ebus_req_l;
   logic          apr_ebus_demand_h;
   logic          apr_ebus_return_h;
   logic          apr_ebus_f01_e_h;
   logic          apr_ebus_send_f02_h;
   logic [DW-1:0] apr_ebus_d_h;
   logic          pi_ebus_req_h;
   logic          ebus_xfer_h;
   logic [DW-1:0] ebus_dev_d_h;
   logic          ebus_timeout_clr_h;
   logic          ebus_grant_apr_h;
   logic          ebus_grant_pi_h;
   logic          ebus_demand_h;
   logic [1:0]    ebus_func_h;
   logic [DW-1:0] ebus_d_out_h;
   logic [DW-1:0] ebus_rd_data_h;
   logic          ebus_rd_valid_h;
   logic          ebus_timeout_h;
   logic          ebus_busy_h;

   modport slave (
      input  apr_ebus_req_l, apr_ebus_demand_h, apr_ebus_return_h,
             apr_ebus_f01_e_h, apr_ebus_send_f02_h, apr_ebus_d_h,
             pi_ebus_req_h, ebus_xfer_h, ebus_dev_d_h, ebus_timeout_clr_h,
      output ebus_grant_apr_h, ebus_grant_pi_h, ebus_demand_h, ebus_func_h,
             ebus_d_out_h, ebus_rd_data_h, ebus_rd_valid_h, ebus_timeout_h,
             ebus_busy_h
   );

   modport master (
      output apr_ebus_req_l, apr_ebus_demand_h, apr_ebus_return_h,
             apr_ebus_f01_e_h, apr_ebus_send_f02_h, apr_ebus_d_h,
             pi_ebus_req_h, ebus_xfer_h, ebus_dev_d_h, ebus_timeout_clr_h,
      input  ebus_grant_apr_h, ebus_grant_pi_h, ebus_demand_h, ebus_func_h,
             ebus_d_out_h, ebus_rd_data_h, ebus_rd_valid_h, ebus_timeout_h,
             ebus_busy_h
   );
endinterface

// File: rtl/ebus_ctl.sv
// EBUS cycle controller: arbitrates APR vs PI, sequences grant/demand/transfer/release,
// captures read data and flags a sticky timeout when no device acknowledges a demand.
module ebus_ctl #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int DW             = 36
) (
   input logic       clk3_ebus_h,
   input logic       mr_reset_03_h,
   ebus_ctl_if.slave bus
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_GRANT_APR = 3'd1;
   localparam logic [2:0] S_GRANT_PI  = 3'd2;
   localparam logic [2:0] S_DEMAND    = 3'd3;
   localparam logic [2:0] S_HOLD      = 3'd4;
   localparam logic [2:0] S_RELEASE   = 3'd5;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [2:0]    state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          f01_q, f01_d;
   logic          f02_q, f02_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          grant_apr_q, grant_apr_d;
   logic          grant_pi_q, grant_pi_d;
   logic          demand_q, demand_d;
   logic [1:0]    func_q, func_d;
   logic [DW-1:0] d_out_q, d_out_d;
   logic [DW-1:0] rd_data_q, rd_data_d;
   logic          rd_valid_q, rd_valid_d;
   logic          timeout_q, timeout_d;
   logic          busy_q, busy_d;
   logic          start_demand;
   logic          apr_done;

   assign apr_done = bus.apr_ebus_return_h || bus.apr_ebus_req_l;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      f01_d        = f01_q;
      f02_d        = f02_q;
      wdata_d      = wdata_q;
      rd_data_d    = rd_data_q;
      rd_valid_d   = 1'b0;
      timeout_d    = bus.ebus_timeout_clr_h ? 1'b0 : timeout_q;
      start_demand = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.pi_ebus_req_h)        state_d = S_GRANT_PI;
            else if (!bus.apr_ebus_req_l) state_d = S_GRANT_APR;
         end
         S_GRANT_PI: begin
            if (!bus.pi_ebus_req_h) state_d = S_RELEASE;
         end
         S_GRANT_APR: begin
            if (bus.apr_ebus_demand_h) start_demand = 1'b1;
            else if (apr_done)         state_d = S_RELEASE;
         end
         S_DEMAND: begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            // Transfer acknowledge outranks a coincident timeout.
            if (bus.ebus_xfer_h) begin
               state_d = S_HOLD;
               if (f01_q) begin
                  rd_data_d  = bus.ebus_dev_d_h;
                  rd_valid_d = 1'b1;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d   = S_HOLD;
               timeout_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (apr_done)                   state_d = S_RELEASE;
            else if (bus.apr_ebus_demand_h) start_demand = 1'b1;
         end
         S_RELEASE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase

      if (start_demand) begin
         state_d = S_DEMAND;
         cnt_d   = '0;
         f01_d   = bus.apr_ebus_f01_e_h;
         f02_d   = bus.apr_ebus_send_f02_h;
         wdata_d = bus.apr_ebus_d_h;
      end

      // Bus outputs are registered from the next state so they track it without a lag.
      grant_apr_d = (state_d == S_GRANT_APR) || (state_d == S_DEMAND) || (state_d == S_HOLD);
      grant_pi_d  = (state_d == S_GRANT_PI);
      demand_d    = (state_d == S_DEMAND);
      func_d      = demand_d ? {f01_d, f02_d} : 2'b00;
      d_out_d     = (demand_d && !f01_d) ? wdata_d : '0;
      busy_d      = (state_d != S_IDLE);
   end

   always_ff @(posedge clk3_ebus_h) begin
      if (mr_reset_03_h) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         f01_q       <= 1'b0;
         f02_q       <= 1'b0;
         wdata_q     <= '0;
         grant_apr_q <= 1'b0;
         grant_pi_q  <= 1'b0;
         demand_q    <= 1'b0;
         func_q      <= '0;
         d_out_q     <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         timeout_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         f01_q       <= f01_d;
         f02_q       <= f02_d;
         wdata_q     <= wdata_d;
         grant_apr_q <= grant_apr_d;
         grant_pi_q  <= grant_pi_d;
         demand_q    <= demand_d;
         func_q      <= func_d;
         d_out_q     <= d_out_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         timeout_q   <= timeout_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.ebus_grant_apr_h = grant_apr_q;
   assign bus.ebus_grant_pi_h  = grant_pi_q;
   assign bus.ebus_demand_h    = demand_q;
   assign bus.ebus_func_h      = func_q;
   assign bus.ebus_d_out_h     = d_out_q;
   assign bus.ebus_rd_data_h   = rd_data_q;
   assign bus.ebus_rd_valid_h  = rd_valid_q;
   assign bus.ebus_timeout_h   = timeout_q;
   assign bus.ebus_busy_h      = busy_q;

endmodule

// File: tb/tb_ebus_ctl.sv
// Bench for ebus_ctl: cycle-by-cycle vector table for read/write/arbitration,
// then hand sequences for timeout, back-to-back demand and reset during DEMAND.
module tb_ebus_ctl;

   localparam int DW = 36;
   localparam logic [DW-1:0] RD = 36'o123456701234;
   localparam logic [DW-1:0] WD = 36'o777000000777;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ebus_ctl_if #(.DW(DW)) bus ();

   ebus_ctl #(.TIMEOUT_CYCLES(64), .DW(DW)) dut (
      .clk3_ebus_h   (clk),
      .mr_reset_03_h (rst),
      .bus           (bus.slave)
   );

   typedef struct {
      logic          rst, req_l, dem, ret, f01, f02, pi, xfer, clr;
      logic [DW-1:0] d, dev;
      logic          e_gapr, e_gpi, e_dem;
      logic [1:0]    e_func;
      logic [DW-1:0] e_dout, e_rdd;
      logic          e_rdv, e_tmo, e_busy;
   } vec_t;

   vec_t tbl[22];

   function automatic vec_t mk(
      input logic r, rq, dm, rt, f1, f2, p, x, c,
      input logic [DW-1:0] d, dv,
      input logic ga, gp, ed, input logic [1:0] ef,
      input logic [DW-1:0] eo, er,
      input logic ev, et, eb);
      vec_t v;
      v.rst = r;   v.req_l = rq; v.dem = dm; v.ret = rt; v.f01 = f1; v.f02 = f2;
      v.pi = p;    v.xfer = x;   v.clr = c;  v.d = d;    v.dev = dv;
      v.e_gapr = ga; v.e_gpi = gp; v.e_dem = ed; v.e_func = ef;
      v.e_dout = eo; v.e_rdd = er; v.e_rdv = ev; v.e_tmo = et; v.e_busy = eb;
      return v;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.apr_ebus_req_l      = 1'b1;
      bus.apr_ebus_demand_h   = 1'b0;
      bus.apr_ebus_return_h   = 1'b0;
      bus.apr_ebus_f01_e_h    = 1'b0;
      bus.apr_ebus_send_f02_h = 1'b0;
      bus.apr_ebus_d_h        = '0;
      bus.pi_ebus_req_h       = 1'b0;
      bus.ebus_xfer_h         = 1'b0;
      bus.ebus_dev_d_h        = '0;
      bus.ebus_timeout_clr_h  = 1'b0;
   endtask

   initial begin
      int n;
      idle_inputs();
      //              rst rq dm rt f1 f2 pi x  c  d        dev     ga gp ed func   dout rdd rv tm bz
      tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, '0,      '0,      0, 0, 0, 2'b00, '0, '0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, '0,      '0,      1, 0, 0, 2'b00, '0, '0, 0, 0, 1);
      tbl[2]  = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 36'o555, '0,      1, 0, 1, 2'b10, '0, '0, 0, 0, 1);
      tbl[3]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, '0,      '0,      1, 0, 1, 2'b10, '0, '0, 0, 0, 1);
      tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, '0,      '0,      1, 0, 1, 2'b10, '0, '0, 0, 0, 1);
      tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, '0,      RD,      1, 0, 0, 2'b00, '0, RD, 1, 0, 1);
      tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, '0,      '0,      1, 0, 0, 2'b00, '0, RD, 0, 0, 1);
      tbl[7]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, '0,      '0,      0, 0, 0, 2'b00, '0, RD, 0, 0, 1);
      tbl[8]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, '0,      '0,      0, 0, 0, 2'b00, '0, RD, 0, 0, 0);
      tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, '0,      '0,      1, 0, 0, 2'b00, '0, RD, 0, 0, 1);
      tbl[10] = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, WD,      '0,      1, 0, 1, 2'b01, WD, RD, 0, 0, 1);
      tbl[11] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 36'o1,   '0,      1, 0, 1, 2'b01, WD, RD, 0, 0, 1);
      tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, '0,      36'o7,   1, 0, 0, 2'b00, '0, RD, 0, 0, 1);
      tbl[13] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, '0,      '0,      0, 0, 0, 2'b00, '0, RD, 0, 0, 1);
      tbl[14] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, '0,      '0,      0, 0, 0, 2'b00, '0, RD, 0, 0, 0);
      tbl[15] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, '0,      '0,      0, 1, 0, 2'b00, '0, RD, 0, 0, 1);
      tbl[16] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, '0,      '0,      0, 1, 0, 2'b00, '0, RD, 0, 0, 1);
      tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, '0,      '0,      0, 0, 0, 2'b00, '0, RD, 0, 0, 1);
      tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, '0,      '0,      0, 0, 0, 2'b00, '0, RD, 0, 0, 0);
      tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, '0,      '0,      1, 0, 0, 2'b00, '0, RD, 0, 0, 1);
      tbl[20] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, '0,      '0,      0, 0, 0, 2'b00, '0, RD, 0, 0, 1);
      tbl[21] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, '0,      '0,      0, 0, 0, 2'b00, '0, RD, 0, 0, 0);

      for (int i = 0; i < 22; i++) begin
         rst                     = tbl[i].rst;
         bus.apr_ebus_req_l      = tbl[i].req_l;
         bus.apr_ebus_demand_h   = tbl[i].dem;
         bus.apr_ebus_return_h   = tbl[i].ret;
         bus.apr_ebus_f01_e_h    = tbl[i].f01;
         bus.apr_ebus_send_f02_h = tbl[i].f02;
         bus.apr_ebus_d_h        = tbl[i].d;
         bus.pi_ebus_req_h       = tbl[i].pi;
         bus.ebus_xfer_h         = tbl[i].xfer;
         bus.ebus_dev_d_h        = tbl[i].dev;
         bus.ebus_timeout_clr_h  = tbl[i].clr;
         step();
         chk($sformatf("v%0d grant_apr", i), DW'(bus.ebus_grant_apr_h), DW'(tbl[i].e_gapr));
         chk($sformatf("v%0d grant_pi", i),  DW'(bus.ebus_grant_pi_h),  DW'(tbl[i].e_gpi));
         chk($sformatf("v%0d demand", i),    DW'(bus.ebus_demand_h),    DW'(tbl[i].e_dem));
         chk($sformatf("v%0d func", i),      DW'(bus.ebus_func_h),      DW'(tbl[i].e_func));
         chk($sformatf("v%0d d_out", i),     bus.ebus_d_out_h,          tbl[i].e_dout);
         chk($sformatf("v%0d rd_data", i),   bus.ebus_rd_data_h,        tbl[i].e_rdd);
         chk($sformatf("v%0d rd_valid", i),  DW'(bus.ebus_rd_valid_h),  DW'(tbl[i].e_rdv));
         chk($sformatf("v%0d timeout", i),   DW'(bus.ebus_timeout_h),   DW'(tbl[i].e_tmo));
         chk($sformatf("v%0d busy", i),      DW'(bus.ebus_busy_h),      DW'(tbl[i].e_busy));
      end

      // Timeout with clear held throughout: set must win over clear on the same edge.
      idle_inputs();
      bus.apr_ebus_req_l = 1'b0;
      step();
      chk("to grant", DW'(bus.ebus_grant_apr_h), DW'(1));
      bus.apr_ebus_demand_h   = 1'b1;
      bus.apr_ebus_f01_e_h    = 1'b1;
      bus.apr_ebus_send_f02_h = 1'b1;
      bus.ebus_timeout_clr_h  = 1'b1;
      step();
      chk("to demand", DW'(bus.ebus_demand_h), DW'(1));
      chk("to func", DW'(bus.ebus_func_h), DW'(2'b11));
      bus.apr_ebus_demand_h = 1'b0;
      n = 1;
      for (int i = 0; i < 300; i++) begin
         step();
         if (bus.ebus_demand_h) n++;
         else break;
      end
      chk("to demand_len", DW'(n), DW'(64));
      chk("to flag_set", DW'(bus.ebus_timeout_h), DW'(1));
      chk("to no_rd_valid", DW'(bus.ebus_rd_valid_h), DW'(0));
      chk("to rd_data_kept", bus.ebus_rd_data_h, RD);
      chk("to grant_held", DW'(bus.ebus_grant_apr_h), DW'(1));
      bus.ebus_timeout_clr_h = 1'b0;
      step();
      chk("to sticky", DW'(bus.ebus_timeout_h), DW'(1));
      bus.ebus_timeout_clr_h = 1'b1;
      step();
      chk("to cleared", DW'(bus.ebus_timeout_h), DW'(0));
      bus.ebus_timeout_clr_h = 1'b0;

      // Transfer on the last counted cycle beats the timeout.
      bus.apr_ebus_demand_h = 1'b1;
      bus.ebus_dev_d_h      = 36'o246;
      step();
      chk("late demand", DW'(bus.ebus_demand_h), DW'(1));
      bus.apr_ebus_demand_h = 1'b0;
      repeat (63) step();
      chk("late demand_at_63", DW'(bus.ebus_demand_h), DW'(1));
      bus.ebus_xfer_h = 1'b1;
      step();
      chk("late demand_drop", DW'(bus.ebus_demand_h), DW'(0));
      chk("late no_timeout", DW'(bus.ebus_timeout_h), DW'(0));
      chk("late rd_valid", DW'(bus.ebus_rd_valid_h), DW'(1));
      chk("late rd_data", bus.ebus_rd_data_h, 36'o246);
      bus.ebus_xfer_h = 1'b0;

      // Back-to-back reads from HOLD without release or regrant.
      bus.apr_ebus_demand_h = 1'b1;
      step();
      chk("b2b demand1", DW'(bus.ebus_demand_h), DW'(1));
      bus.apr_ebus_demand_h = 1'b0;
      bus.ebus_xfer_h       = 1'b1;
      bus.ebus_dev_d_h      = 36'o111122223333;
      step();
      chk("b2b rd_valid1", DW'(bus.ebus_rd_valid_h), DW'(1));
      chk("b2b rd_data1", bus.ebus_rd_data_h, 36'o111122223333);
      bus.ebus_xfer_h       = 1'b0;
      bus.apr_ebus_demand_h = 1'b1;
      step();
      chk("b2b demand2", DW'(bus.ebus_demand_h), DW'(1));
      chk("b2b grant2", DW'(bus.ebus_grant_apr_h), DW'(1));
      chk("b2b rd_valid_pulse", DW'(bus.ebus_rd_valid_h), DW'(0));
      bus.apr_ebus_demand_h = 1'b0;
      bus.ebus_xfer_h       = 1'b1;
      bus.ebus_dev_d_h      = 36'o444455556666;
      step();
      chk("b2b rd_valid2", DW'(bus.ebus_rd_valid_h), DW'(1));
      chk("b2b rd_data2", bus.ebus_rd_data_h, 36'o444455556666);
      bus.ebus_xfer_h = 1'b0;
      step();
      chk("b2b rd_valid_end", DW'(bus.ebus_rd_valid_h), DW'(0));
      chk("b2b rd_data_hold", bus.ebus_rd_data_h, 36'o444455556666);

      // Reset in DEMAND discards the cycle; held request is regranted after reset.
      bus.apr_ebus_demand_h = 1'b1;
      bus.apr_ebus_f01_e_h  = 1'b0;
      bus.apr_ebus_d_h      = WD;
      step();
      chk("rst d_out_before", bus.ebus_d_out_h, WD);
      bus.apr_ebus_demand_h = 1'b0;
      rst = 1'b1;
      step();
      chk("rst grant", DW'(bus.ebus_grant_apr_h), DW'(0));
      chk("rst demand", DW'(bus.ebus_demand_h), DW'(0));
      chk("rst d_out", bus.ebus_d_out_h, '0);
      chk("rst rd_data", bus.ebus_rd_data_h, '0);
      chk("rst busy", DW'(bus.ebus_busy_h), DW'(0));
      rst = 1'b0;
      step();
      chk("rst regrant", DW'(bus.ebus_grant_apr_h), DW'(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ebus_ctl.md
# ebus_ctl

EBUS cycle controller for the EBOX side of the machine. It sits directly downstream of the APR board's EBUS request/demand outputs. It arbitrates the bus between the APR and the PI board, sequences grant → demand → transfer → release, and drives function and write data onto the EBUS. For read functions it captures device data back for the APR, and it flags a sticky timeout when no device answers a demand.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: cycles in DEMAND without a transfer acknowledge before timeout; legal range 2–255.
- DW, 36: EBUS data width.

Ports:
- clk3_ebus_h  in  1  system clock; all logic on the rising edge.
- mr_reset_03_h  in  1  synchronous reset, active high.
- apr_ebus_req_l  in  1  APR bus request, active low.
- apr_ebus_demand_h  in  1  APR requests a demand cycle; valid only while granted.
- apr_ebus_return_h  in  1  APR finished with the bus.
- apr_ebus_f01_e_h  in  1  function bit 01; 1 = read (data in).
- apr_ebus_send_f02_h  in  1  function bit 02.
- apr_ebus_d_h  in  DW  APR write data (ebus_dNN_e_h bundle).
- pi_ebus_req_h  in  1  PI board bus request, active high.
- ebus_xfer_h  in  1  device transfer acknowledge.
- ebus_dev_d_h  in  DW  device read data.
- ebus_timeout_clr_h  in  1  clears the sticky timeout flag.
- ebus_grant_apr_h  out  1  bus granted to APR.
- ebus_grant_pi_h  out  1  bus granted to PI.
- ebus_demand_h  out  1  EBUS demand line.
- ebus_func_h  out  2  {f01,f02}; valid while demand is asserted, otherwise 0.
- ebus_d_out_h  out  DW  write data; zero except during DEMAND of a write.
- ebus_rd_data_h  out  DW  last captured read data.
- ebus_rd_valid_h  out  1  one-cycle pulse when ebus_rd_data_h updates.
- ebus_timeout_h  out  1  sticky demand-timeout flag.
- ebus_busy_h  out  1  FSM not IDLE.

## Operation
- States: IDLE, GRANT_APR, GRANT_PI, DEMAND, HOLD, RELEASE.
- IDLE:
  - pi_ebus_req_h → GRANT_PI. PI has fixed priority over APR.
  - else !apr_ebus_req_l → GRANT_APR.
  - Requests are sampled only in IDLE.
- GRANT_PI: hold ebus_grant_pi_h while pi_ebus_req_h = 1; on drop → RELEASE.
- GRANT_APR:
  - apr_ebus_demand_h → DEMAND; latch f01, f02 and apr_ebus_d_h; clear the timeout counter.
  - apr_ebus_return_h or apr_ebus_req_l = 1 → RELEASE.
- DEMAND:
  - Drives ebus_demand_h, ebus_func_h, and ebus_d_out_h (write data only when f01 = 0).
  - The counter increments each cycle.
  - ebus_xfer_h = 1 → HOLD. If f01 = 1, capture ebus_dev_d_h into ebus_rd_data_h and pulse ebus_rd_valid_h.
  - Counter reaches TIMEOUT_CYCLES−1 without xfer → set ebus_timeout_h → HOLD. No data capture, no rd_valid.
  - xfer and timeout in the same cycle: xfer wins; timeout is not set.
- HOLD:
  - Demand and data are deasserted; the APR grant stays asserted.
  - apr_ebus_return_h or apr_ebus_req_l = 1 → RELEASE.
  - apr_ebus_demand_h = 1 again while request is held → DEMAND. This is a back-to-back cycle and needs no re-arbitration.
- RELEASE: one cycle with all grants, demand and data at 0 → IDLE. This guarantees a bus-dead cycle between owners.
- ebus_timeout_h:
  - Clears on ebus_timeout_clr_h.
  - A set in the same cycle as the clear wins.
- ebus_rd_data_h holds its value until the next capture.

## Timing
- Reset: all outputs 0, state IDLE, counter 0, ebus_rd_data_h 0, ebus_timeout_h 0.
- Reset asserted mid-cycle in any state forces IDLE on the next edge and drops grant/demand, discarding the cycle.
- All outputs are registered.
- Request seen in IDLE at edge n → grant high after edge n+1.
- apr_ebus_demand_h seen in GRANT_APR or HOLD at edge n → ebus_demand_h high after edge n+1.
- ebus_xfer_h seen at edge n → demand low and rd_valid/rd_data updated after edge n+1.
- Timeout: demand is high for exactly TIMEOUT_CYCLES cycles, then drops together with timeout rising.
- Minimum APR read cycle (request to rd_valid): 4 cycles with immediate xfer.
- Counter is 8 bits wide and saturates; it never wraps inside DEMAND.

## Test plan
- APR read: req low, demand at grant+1, xfer on the 3rd demand cycle with dev_d = 36'o123456_701234 → rd_valid pulse once, rd_data = 36'o123456701234; return → RELEASE → IDLE; busy low.
- APR write, f01 = 0, f02 = 1, d = 36'o777000_000777: ebus_d_out_h and func = 2'b01 valid only during DEMAND; no rd_valid; xfer → HOLD.
- Simultaneous PI and APR request in IDLE → PI granted. After PI drops: one RELEASE cycle with both grants 0, then APR granted.
- No xfer, TIMEOUT_CYCLES = 64 → demand high exactly 64 cycles, timeout set, rd_data unchanged. Then: clr clears the flag; xfer on the cycle the count hits 63 → no timeout.
- Reset asserted in DEMAND → next edge: all outputs 0, IDLE. A held request is re-granted 1 cycle after reset deasserts.
- Back-to-back: second demand in HOLD → DEMAND with no RELEASE or regrant; two rd_valid pulses with the correct data for each cycle.
